wr_ptr_full: RTL and testbench
==============================

// Module: wr_ptr_full
// PURPOSE
// - Write-domain pointer and full-flag generator for the async FIFO. Runs on wclk.
// - Consumes the read pointer after it has been synchronized into wclk (rptr_s, Gray).
// - Produces the RAM write address/enable and the Gray write pointer sent to the write-to-read synchronizer.
// - Produces full, almost-full, fill-level and sticky-overflow status for the writer.
// PARAMETERS
// - Addr_Width    9      RAM address bits; FIFO depth = 2**Addr_Width; must be >= 2.
// - AFULL_THRESH  508    walmost_full asserts when fill level >= this value; range 1..2**Addr_Width.
// PORTS
// - wclk          in   1             Write clock.
// - wrst          in   1             Reset: synchronous, active-low.
// - winc          in   1             Write request from the producer.
// - rptr_s        in   Addr_Width+1  Read pointer, Gray code, already 2-flop synchronized into wclk.
// - waddr         out  Addr_Width    Binary RAM write address.
// - wen           out  1             RAM write enable.
// - wptr          out  Addr_Width+1  Gray write pointer, registered; drives the wr->rd synchronizer.
// - wfull         out  1             FIFO full, registered.
// - walmost_full  out  1             Fill level >= AFULL_THRESH, registered.
// - wlevel        out  Addr_Width+1  Fill level as seen from wclk (conservative), registered.
// - woverflow     out  1             Sticky flag: a write was attempted while full.
// BEHAVIOUR
// - Internal state: binary pointer wbin[Addr_Width:0] and Gray pointer wptr, both registered.
// - Enable/address (combinational):
//   - wen = winc & ~wfull.
//   - waddr = wbin[Addr_Width-1:0].
// - Next-state pointer:
//   - wbin_next  = wbin + wen, modulo 2**(Addr_Width+1).
//   - wgray_next = (wbin_next >> 1) ^ wbin_next.
//   - Every wclk edge: wbin <= wbin_next, wptr <= wgray_next.
// - wfull, registered every edge:
//   - wfull <= (wgray_next == {~rptr_s[AW:AW-1], rptr_s[AW-2:0]}), where AW = Addr_Width.
//   - Asserts on the same edge as the write that fills the last slot. No extra latency.
// - wlevel / walmost_full:
//   - rbin_s = Gray-to-binary of rptr_s (combinational XOR prefix).
//   - wlevel <= wbin_next - rbin_s, modulo 2**(AW+1); range 0..2**AW.
//   - walmost_full <= (wbin_next - rbin_s) >= AFULL_THRESH.
// - woverflow:
//   - Set on the edge where winc=1 and wfull=1.
//   - Cleared only by reset.
//   - The dropped write does not move the pointers.
// - Status flags are recomputed every cycle, including cycles with no write.
//   - Read progress lowers wfull, wlevel and walmost_full one wclk after rptr_s changes.
//   - End to end this is 3 wclk after rptr changes in the read domain (2 sync + 1 register).
//   - Full is therefore pessimistic: it never reports free space that does not exist.
// - Wrap-around:
//   - wbin and wptr wrap from 2**(AW+1)-1 to 0; waddr wraps from 2**AW-1 to 0.
//   - The MSB-inversion full compare handles the wrap.
// - Reset (wrst=0 at a wclk edge):
//   - wbin, wptr, wlevel = 0; wfull, walmost_full, woverflow = 0.
//   - wen is forced to 0 during the reset cycle.
//   - Reset mid-operation discards all state and the in-flight write. The read side must be reset together with it.
// - rptr_s is trusted to be a valid Gray code; no check is performed on it.
// TESTING  (Addr_Width=2, AFULL_THRESH=3, depth 4)
// - Reset: wrst=0 for 1 edge with winc=1 -> wptr=0, waddr=0, wen=0, wfull=0, wlevel=0, woverflow=0.
// - Fill: rptr_s=0, winc=1 for 4 edges -> wptr 1,3,2,6; waddr 1,2,3,0; walmost_full=1 after edge 3; wfull=1, wlevel=4 after edge 4.
// - Overflow: while full, winc=1 for 1 edge -> wen=0, wptr stays 6, woverflow=1 and remains 1 after winc=0.
// - Drain: full, rptr_s=1 (gray of 1), winc=0 -> next edge wfull=0, wlevel=3, walmost_full=1; rptr_s=3 -> wlevel=2, walmost_full=0.
// - Wrap: 10 writes with rptr_s trailing by 1 -> wptr sequence wraps 4->0 (gray 6->4->0); wfull stays 0; no overflow.
// - Simultaneous: full, winc=1 and rptr_s advances on the same edge -> write is dropped (wen=0), woverflow=1; next edge wfull=0.
// - Reset mid-full: wrst=0 while wfull=1, woverflow=1 -> next edge all outputs 0.

Source files
------------

// File: rtl/wr_ptr_full.sv
// Write-domain pointer and full/status generator for the async FIFO.
// Tracks the binary and Gray write pointers and derives full, almost-full, level and overflow from the synchronized read pointer.
module wr_ptr_full #(
    parameter int Addr_Width   = 9,
    parameter int AFULL_THRESH = 508
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  winc,
    input  logic [Addr_Width:0]   rptr_s,
    output logic [Addr_Width-1:0] waddr,
    output logic                  wen,
    output logic [Addr_Width:0]   wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [Addr_Width:0]   wlevel,
    output logic                  woverflow
);

    localparam int AW = Addr_Width;
    localparam int PW = Addr_Width + 1;
    localparam logic [AW:0] THRESH = PW'(AFULL_THRESH);

    logic [AW:0] wbin;
    logic [AW:0] wbin_next;
    logic [AW:0] wgray_next;
    logic [AW:0] rbin_s;
    logic [AW:0] rptr_full;
    logic [AW:0] level_next;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    for (genvar g = 0; g <= AW; g++) begin : g_g2b
        assign rbin_s[g] = ^rptr_s[AW:g];
    end

    always_comb begin
        wen        = winc & ~wfull & wrst;
        waddr      = wbin[AW-1:0];
        wbin_next  = wbin + PW'(wen);
        wgray_next = (wbin_next >> 1) ^ wbin_next;
        rptr_full  = {~rptr_s[AW:AW-1], rptr_s[AW-2:0]};
        level_next = wbin_next - rbin_s;
    end

    always_ff @(posedge wclk) begin
        if (!wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= (wgray_next == rptr_full);
            walmost_full <= (level_next >= THRESH);
            wlevel       <= level_next;
            woverflow    <= woverflow | (winc & wfull);
        end
    end

endmodule

// File: tb/tb_wr_ptr_full.sv
// Scoreboard bench for wr_ptr_full at Addr_Width=2, AFULL_THRESH=3 (depth 4).
// A bench-side occupancy model predicts each edge's outputs; predictions are queued and checked after the edge.
module tb_wr_ptr_full;

    logic       wclk = 1'b0;
    logic       wrst = 1'b0;
    logic       winc = 1'b0;
    logic [2:0] rptr_s = '0;
    logic [1:0] waddr;
    logic       wen;
    logic [2:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [2:0] wlevel;
    logic       woverflow;

    wr_ptr_full #(.Addr_Width(2), .AFULL_THRESH(3)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .rptr_s       (rptr_s),
        .waddr        (waddr),
        .wen          (wen),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic [2:0] wptr;
        logic [1:0] waddr;
        logic [2:0] level;
        logic       full;
        logic       af;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int   m_bin  = 0;
    logic m_full = 1'b0;
    logic m_ovf  = 1'b0;
    int   rb     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] to_gray(input int b);
        logic [2:0] x;
        x = 3'(b);
        return x ^ (x >> 1);
    endfunction

    // Drive one edge's inputs, predict its outputs, then compare after the edge.
    task automatic cycle(input logic w, input int rbin, input logic rst);
        exp_t e;
        int   nb;
        int   lvl;
        logic ew;
        wrst   = rst;
        winc   = w;
        rptr_s = to_gray(rbin);
        #1;
        ew = rst & w & ~m_full;
        check("wen", 32'(wen), 32'(ew));
        if (!rst) begin
            m_bin  = 0;
            m_full = 1'b0;
            m_ovf  = 1'b0;
            lvl    = 0;
        end else begin
            m_ovf  = m_ovf | (w & m_full);
            nb     = (m_bin + int'(ew)) % 8;
            lvl    = (nb - rbin + 8) % 8;
            m_bin  = nb;
            m_full = (lvl == 4);
        end
        e.wptr  = to_gray(m_bin);
        e.waddr = 2'(m_bin % 4);
        e.level = 3'(lvl);
        e.full  = m_full;
        e.af    = (lvl >= 3);
        e.ovf   = m_ovf;
        sb.push_back(e);
        @(posedge wclk);
        #1;
        e = sb.pop_front();
        check("wptr",   32'(wptr),         32'(e.wptr));
        check("waddr",  32'(waddr),        32'(e.waddr));
        check("wlevel", 32'(wlevel),       32'(e.level));
        check("wfull",  32'(wfull),        32'(e.full));
        check("afull",  32'(walmost_full), 32'(e.af));
        check("ovf",    32'(woverflow),    32'(e.ovf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [2:0] fill_seq [4];
        fill_seq = '{3'd1, 3'd3, 3'd2, 3'd6};

        // reset with a write request pending
        cycle(1'b1, 0, 1'b0);

        // fill to full against an idle reader
        rb = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, rb, 1'b1);
            check("fill_wptr", 32'(wptr), 32'(fill_seq[i]));
        end
        check("full_lvl", 32'(wlevel), 32'd4);

        // overflow is dropped and sticky
        cycle(1'b1, rb, 1'b1);
        check("ovf_hold_wptr", 32'(wptr), 32'd6);
        cycle(1'b0, rb, 1'b1);
        cycle(1'b0, rb, 1'b1);
        check("ovf_sticky", 32'(woverflow), 32'd1);

        // drain via read-pointer progress
        rb = 1;
        cycle(1'b0, rb, 1'b1);
        rb = 2;
        cycle(1'b0, rb, 1'b1);

        // wrap with the reader trailing one behind
        for (int i = 0; i < 10; i++) begin
            rb = (m_bin + 7) % 8;
            cycle(1'b1, rb, 1'b1);
        end

        // write attempted on the edge the reader frees a slot
        rb = 0;
        cycle(1'b0, rb, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, rb, 1'b1);
        rb = 1;
        cycle(1'b1, rb, 1'b1);
        check("simul_ovf", 32'(woverflow), 32'd1);
        check("simul_full", 32'(wfull), 32'd0);

        // refill, overflow, then reset while full
        cycle(1'b1, rb, 1'b1);
        cycle(1'b1, rb, 1'b1);
        cycle(1'b0, rb, 1'b0);
        check("rst_mid_full", 32'({wptr, wfull, woverflow, wlevel}), 32'd0);

        // random producer/consumer traffic
        rb = 0;
        for (int i = 0; i < 80; i++) begin
            if (((m_bin - rb + 8) % 8) > 0 && $urandom_range(0, 1) == 1)
                rb = (rb + 1) % 8;
            cycle(1'($urandom_range(0, 1)), rb, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
